// File: rtl/lr35902_pkg.sv
// Shared constants and types for the LR35902 interrupt logic and its bus decoder.
package lr35902_pkg;

    localparam int INT_VBLANK = 0;
    localparam int INT_STAT   = 1;
    localparam int INT_TIMER  = 2;
    localparam int INT_SERIAL = 3;
    localparam int INT_JOYPAD = 4;
    localparam int INT_COUNT  = 5;

    localparam logic [7:0]  INT_VECTOR_BASE = 8'h40;
    localparam logic [15:0] ADDR_IF         = 16'hFF0F;
    localparam logic [15:0] ADDR_IE         = 16'hFFFF;

    typedef enum logic {
        IRQ_IDLE     = 1'b0,
        IRQ_DISPATCH = 1'b1
    } irq_state_e;

    // Restart vectors are spaced 8 bytes apart starting at 0x40.
    function automatic logic [7:0] vector_for(input logic [2:0] idx);
        return INT_VECTOR_BASE + {2'b00, idx, 3'b000};
    endfunction

endpackage

// File: rtl/lr35902_prio5.sv
// Lowest-set-bit encoder over the five interrupt sources; bit 0 has top priority.
module lr35902_prio5 (
    input  logic [4:0] req,
    output logic       found,
    output logic [2:0] idx
);

    always_comb begin
        found = |req;
        idx   = 3'd0;
        for (int i = 4; i >= 0; i--) begin
            if (req[i]) idx = 3'(i);
        end
    end

endmodule

// File: rtl/lr35902_irq.sv
// IF/IE register pair with edge-strobed bus access and an ack-driven dispatch FSM
// that clears the winning request and presents its restart vector.
module lr35902_irq
    import lr35902_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] din,
    output logic [7:0] dout,
    input  logic       adr,
    input  logic       read,
    input  logic       write,
    input  logic [4:0] src,
    input  logic       ime,
    output logic       pending,
    output logic       irq,
    input  logic       ack,
    output logic [7:0] vector,
    output logic       vector_valid,
    output irq_state_e state_dbg
);

    // Bus handshake: a read is the 0->1 transition of read, sampled on clk;
    // a write is the 1->0 transition of write, committed one edge later.
    logic [4:0] if_r;
    logic [7:0] ie_r;
    logic       read_q;
    logic       write_q;
    logic       wr_pend;
    logic       wr_adr;
    logic [7:0] wr_data;
    irq_state_e state;

    logic [4:0] masked;
    logic       found;
    logic [2:0] win_idx;
    logic       dispatch_go;
    logic [4:0] if_next;

    assign masked = if_r & ie_r[4:0];

    lr35902_prio5 u_prio (
        .req   (masked),
        .found (found),
        .idx   (win_idx)
    );

    assign pending     = found;
    assign irq         = found & ime & (state == IRQ_IDLE);
    assign dispatch_go = (state == IRQ_IDLE) && ack;
    assign state_dbg   = state;

    // Write first, then the dispatch clear, then new requests so a set always wins.
    always_comb begin
        if_next = if_r;
        if (wr_pend && !wr_adr) if_next = wr_data[4:0];
        if (dispatch_go && found) if_next[win_idx] = 1'b0;
        if_next = if_next | src;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            read_q  <= 1'b0;
            write_q <= 1'b0;
            wr_pend <= 1'b0;
            wr_adr  <= 1'b0;
            wr_data <= 8'h00;
            dout    <= 8'h00;
            if_r    <= 5'h00;
            ie_r    <= 8'h00;
        end else begin
            read_q  <= read;
            write_q <= write;
            wr_pend <= write_q && !write;
            if (write_q && !write) begin
                wr_adr  <= adr;
                wr_data <= din;
            end
            if (read && !read_q) dout <= adr ? ie_r : {3'b111, if_r};
            if (wr_pend && wr_adr) ie_r <= wr_data;
            if_r <= if_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IRQ_IDLE;
            vector       <= 8'h00;
            vector_valid <= 1'b0;
        end else begin
            case (state)
                IRQ_IDLE: begin
                    if (ack) begin
                        state        <= IRQ_DISPATCH;
                        vector       <= found ? vector_for(win_idx) : 8'h00;
                        vector_valid <= 1'b1;
                    end
                end
                IRQ_DISPATCH: begin
                    if (!ack) begin
                        state        <= IRQ_IDLE;
                        vector_valid <= 1'b0;
                    end
                end
                default: state <= IRQ_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lr35902_irq.sv
// Directed bench for lr35902_irq: cycle-level reference model, per-cycle output
// compare and hand-computed literal checks for each scenario.
module tb_lr35902_irq;
    import lr35902_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] din = 8'h00;
    logic [7:0] dout;
    logic       adr = 1'b0;
    logic       read = 1'b0;
    logic       write = 1'b0;
    logic [4:0] src = 5'h00;
    logic       ime = 1'b0;
    logic       pending;
    logic       irq;
    logic       ack = 1'b0;
    logic [7:0] vector;
    logic       vector_valid;
    irq_state_e state_dbg;

    int total = 0;
    int bad   = 0;

    lr35902_irq dut (
        .clk          (clk),
        .reset        (reset),
        .din          (din),
        .dout         (dout),
        .adr          (adr),
        .read         (read),
        .write        (write),
        .src          (src),
        .ime          (ime),
        .pending      (pending),
        .irq          (irq),
        .ack          (ack),
        .vector       (vector),
        .vector_valid (vector_valid),
        .state_dbg    (state_dbg)
    );

    // clock / reset
    always #5 clk = ~clk;

    // reference model: registers as plain integers, writes queued with the cycle they land
    typedef struct {
        int   due;
        bit   adr;
        byte  data;
    } wr_t;

    int   cyc = 0;
    int   m_if = 0;
    int   m_ie = 0;
    int   m_dout = 0;
    int   m_vec = 0;
    bit   m_valid = 0;
    bit   m_disp = 0;
    bit   m_read_prev = 0;
    bit   m_write_prev = 0;
    wr_t  wq[$];
    logic [7:0] exp_q[$];

    function automatic int lowest_set(input int v);
        for (int n = 0; n < 5; n++) if ((v >> n) & 1) return n;
        return -1;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_if = 0; m_ie = 0; m_dout = 0; m_vec = 0; m_valid = 0; m_disp = 0;
            m_read_prev = 0; m_write_prev = 0;
            wq.delete();
        end else begin
            int old_if;
            int old_ie;
            int n;
            cyc++;
            old_if = m_if;
            old_ie = m_ie;
            while (wq.size() > 0 && wq[0].due == cyc) begin
                if (wq[0].adr) m_ie = int'(wq[0].data) & 8'hFF;
                else           m_if = int'(wq[0].data) & 5'h1F;
                void'(wq.pop_front());
            end
            if (!m_disp && ack) begin
                n = lowest_set(old_if & old_ie & 5'h1F);
                if (n >= 0) begin
                    m_if = m_if & ~(1 << n);
                    m_vec = 64 + 8 * n;
                end else begin
                    m_vec = 0;
                end
                m_valid = 1;
                m_disp = 1;
            end else if (m_disp && !ack) begin
                m_disp = 0;
                m_valid = 0;
            end
            m_if = m_if | int'(src);
            if (read && !m_read_prev) m_dout = adr ? old_ie : (8'hE0 | old_if);
            if (m_write_prev && !write) wq.push_back('{due: cyc + 1, adr: adr, data: din});
            m_read_prev = read;
            m_write_prev = write;
        end
    end

    // scoreboard
    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            bit m_pend;
            m_pend = ((m_if & m_ie & 5'h1F) != 0);
            chk("dout",         dout,                  8'(m_dout));
            chk("pending",      {7'd0, pending},       {7'd0, m_pend});
            chk("irq",          {7'd0, irq},           {7'd0, m_pend & ime & !m_disp});
            chk("vector",       vector,                8'(m_vec));
            chk("vector_valid", {7'd0, vector_valid},  {7'd0, m_valid});
            chk("state",        {7'd0, state_dbg},     {7'd0, m_disp});
        end
    end

    // driver tasks: inputs change 2 time units after the rising edge
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic do_write(input logic a, input logic [7:0] d);
        adr = a; din = d; write = 1'b1;
        tick();
        write = 1'b0;
        tick(2);
    endtask

    task automatic do_read(input logic a, input logic [7:0] expected, input string name);
        adr = a; read = 1'b1;
        tick();
        read = 1'b0;
        settle();
        chk(name, dout, expected);
        tick();
    endtask

    task automatic pulse_src(input logic [4:0] s);
        src = s;
        tick();
        src = 5'h00;
    endtask

    task automatic do_ack(input logic [7:0] exp_vec, input string name);
        ack = 1'b1;
        tick();
        settle();
        chk(name, vector, exp_vec);
        chk({name, "_valid"}, {7'd0, vector_valid}, 8'h01);
        tick();
        ack = 1'b0;
        tick(2);
    endtask

    task automatic hard_reset();
        #1 reset = 1'b0;
        #1;
        chk("rst_dout",    dout,                 8'h00);
        chk("rst_vector",  vector,               8'h00);
        chk("rst_valid",   {7'd0, vector_valid}, 8'h00);
        chk("rst_irq",     {7'd0, irq},          8'h00);
        chk("rst_pending", {7'd0, pending},      8'h00);
        tick();
        reset = 1'b1;
        tick();
    endtask

    initial begin
        exp_q = '{8'h50, 8'hE0, 8'h48, 8'h58, 8'h60, 8'h1F, 8'h00, 8'hE1, 8'hE1, 8'h50, 8'hE4};
        #3;
        hard_reset();

        // timer request
        do_write(1'b1, 8'h04);
        ime = 1'b1;
        pulse_src(5'b00100);
        settle();
        chk("timer_irq", {7'd0, irq}, 8'h01);
        tick();
        do_ack(exp_q.pop_front(), "timer_vec");
        do_read(1'b0, exp_q.pop_front(), "timer_if");

        // priority among three sources
        do_write(1'b1, 8'h1F);
        pulse_src(5'b11010);
        tick();
        do_ack(exp_q.pop_front(), "prio_vec1");
        do_ack(exp_q.pop_front(), "prio_vec2");
        do_ack(exp_q.pop_front(), "prio_vec3");
        do_read(1'b1, exp_q.pop_front(), "ie_read");

        // cancellation by IE write before ack
        ime = 1'b0;
        do_write(1'b1, 8'h01);
        pulse_src(5'b00001);
        tick();
        do_write(1'b1, 8'h00);
        tick();
        do_ack(exp_q.pop_front(), "cancel_vec");
        do_read(1'b0, exp_q.pop_front(), "cancel_if");

        // source pulse lands on the same edge as an IF write of zero
        do_write(1'b0, 8'h1E);
        adr = 1'b0; din = 8'h00; write = 1'b1;
        tick();
        write = 1'b0;
        tick();
        pulse_src(5'b00001);
        tick();
        do_read(1'b0, exp_q.pop_front(), "wr_set_if");

        // source pulse on the same edge as the ack that clears it
        do_write(1'b0, 8'h04);
        do_write(1'b1, 8'h04);
        src = 5'b00100;
        ack = 1'b1;
        tick();
        src = 5'h00;
        settle();
        chk("clr_set_vec", vector, exp_q.pop_front());
        tick();
        ack = 1'b0;
        tick(2);
        do_read(1'b0, exp_q.pop_front(), "clr_set_if");

        // masking: pending without irq while ime is low
        do_write(1'b0, 8'h10);
        do_write(1'b1, 8'h10);
        settle();
        chk("mask_pending", {7'd0, pending}, 8'h01);
        chk("mask_irq",     {7'd0, irq},     8'h00);
        tick();
        ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            settle();
            chk("mask_irq_ack", {7'd0, irq}, 8'h00);
        end
        tick();
        ack = 1'b0;
        tick(2);

        // reset in the middle of a dispatch
        ime = 1'b1;
        pulse_src(5'b01000);
        do_write(1'b1, 8'h08);
        ack = 1'b1;
        tick();
        settle();
        chk("pre_rst_valid", {7'd0, vector_valid}, 8'h01);
        ack = 1'b0;
        hard_reset();
        do_read(1'b0, 8'hE0, "post_rst_if");
        do_read(1'b1, 8'h00, "post_rst_ie");

        tick(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
